// File: rtl/noc_pkg.sv
// Shared definitions for the page-rank NoC fetch path: packet field positions,
// page id width, fetch FSM states and the request packing helper.
package noc_pkg;

  localparam int PAGE_ID_W   = 6;
  localparam int REQ_W       = 7;
  localparam int REQ_VLD     = 6;
  localparam int REQ_ID_MSB  = 5;
  localparam int RSP_VLD     = 0;
  localparam int RSP_ID_LSB  = 1;
  localparam int RSP_VAL_LSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } fetch_state_e;

  function automatic logic [REQ_W-1:0] pack_req(input logic [PAGE_ID_W-1:0] id);
    logic [REQ_W-1:0] r;
    r                          = '0;
    r[REQ_VLD]                 = 1'b1;
    r[REQ_ID_MSB -: PAGE_ID_W] = id;
    return r;
  endfunction

endpackage

// File: rtl/fetch_scoreboard.sv
// Outstanding-fetch table: allocation, response matching, per-entry timeout
// and retry bookkeeping, with lowest-index priority everywhere.
module fetch_scoreboard
  import noc_pkg::*;
#(
  parameter int MAX_OUT   = 4,
  parameter int MAX_WAIT  = 31,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc,
  input  logic [PAGE_ID_W-1:0] alloc_id,
  input  logic                 rsp_vld,
  input  logic [PAGE_ID_W-1:0] rsp_id,
  output logic                 free_any,
  output logic                 due_any,
  output logic [PAGE_ID_W-1:0] due_id,
  output logic                 hit,
  output logic                 abandon,
  output logic                 any_busy
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  logic [MAX_OUT-1:0]   busy_r;
  logic [PAGE_ID_W-1:0] id_r    [MAX_OUT];
  logic [WAIT_W-1:0]    wait_r  [MAX_OUT];
  logic [RETRY_W-1:0]   retry_r [MAX_OUT];

  logic [MAX_OUT-1:0]   match_s;
  logic [MAX_OUT-1:0]   alloc_s;
  logic [MAX_OUT-1:0]   retry_s;
  logic [MAX_OUT-1:0]   abandon_s;
  logic [PAGE_ID_W-1:0] due_id_s;
  logic                 hit_s;
  logic                 got_free_s;
  logic                 due_s;

  // Lowest-index pick of the matching, free and retry-due entries
  always_comb begin
    match_s    = '0;
    alloc_s    = '0;
    retry_s    = '0;
    abandon_s  = '0;
    due_id_s   = '0;
    hit_s      = 1'b0;
    got_free_s = 1'b0;
    due_s      = 1'b0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (busy_r[i] && rsp_vld && (id_r[i] == rsp_id) && !hit_s) begin
        match_s[i] = 1'b1;
        hit_s      = 1'b1;
      end else begin
        match_s[i] = 1'b0;
      end
    end
    for (int i = 0; i < MAX_OUT; i++) begin
      if (!busy_r[i] && alloc && !got_free_s) begin
        alloc_s[i] = 1'b1;
        got_free_s = 1'b1;
      end else begin
        alloc_s[i] = 1'b0;
      end
    end
    // A response landing on the timeout cycle wins over retry and abandon
    for (int i = 0; i < MAX_OUT; i++) begin
      if (busy_r[i] && (wait_r[i] == WAIT_MAX) && !match_s[i]) begin
        if (retry_r[i] != RETRY_MAX) begin
          if (!due_s) begin
            retry_s[i] = 1'b1;
            due_s      = 1'b1;
            due_id_s   = id_r[i];
          end else begin
            retry_s[i] = 1'b0;
          end
        end else begin
          abandon_s[i] = 1'b1;
        end
      end else begin
        retry_s[i]   = 1'b0;
        abandon_s[i] = 1'b0;
      end
    end
  end

  // Entry update: allocate, free on match or abandon, re-arm on retry, else age
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        id_r[i]    <= '0;
        wait_r[i]  <= '0;
        retry_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (alloc_s[i]) begin
          busy_r[i]  <= 1'b1;
          id_r[i]    <= alloc_id;
          wait_r[i]  <= '0;
          retry_r[i] <= '0;
        end else if (match_s[i] || abandon_s[i]) begin
          busy_r[i] <= 1'b0;
        end else if (retry_s[i]) begin
          wait_r[i]  <= '0;
          retry_r[i] <= retry_r[i] + 1'b1;
        end else if (busy_r[i] && (wait_r[i] != WAIT_MAX)) begin
          wait_r[i] <= wait_r[i] + 1'b1;
        end
      end
    end
  end

  assign free_any = ~&busy_r;
  assign due_any  = due_s;
  assign due_id   = due_id_s;
  assign hit      = hit_s;
  assign abandon  = |abandon_s;
  assign any_busy = |busy_r;

endmodule

// File: rtl/noc_fetch_ctrl.sv
// Per-engine fetch controller: accepts page ids, issues NoC requests with
// retry, sums matched replies with saturation and reports one result per batch.
module noc_fetch_ctrl
  import noc_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SUM_W     = 24,
  parameter int MAX_OUT   = 4,
  parameter int MAX_WAIT  = 31,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [PAGE_ID_W-1:0] cmd_page_id,
  input  logic                 cmd_last,
  output logic [REQ_W-1:0]     request,
  input  logic [DATA_W+6:0]    response,
  output logic                 sum_valid,
  output logic [SUM_W-1:0]     sum,
  output logic                 sum_err
);

  fetch_state_e         state_r;
  fetch_state_e         state_s;
  logic [REQ_W-1:0]     request_r;
  logic [SUM_W-1:0]     sum_r;
  logic                 sum_err_r;
  logic                 sum_valid_r;

  logic                 open_s;
  logic                 accept_s;
  logic                 free_any_s;
  logic                 due_any_s;
  logic [PAGE_ID_W-1:0] due_id_s;
  logic                 hit_s;
  logic                 abandon_s;
  logic                 any_busy_s;
  logic [DATA_W-1:0]    rsp_val_s;
  logic [SUM_W:0]       sum_ext_s;
  logic [SUM_W-1:0]     sum_sat_s;

  assign rsp_val_s = response[RSP_VAL_LSB +: DATA_W];

  fetch_scoreboard #(
    .MAX_OUT   (MAX_OUT),
    .MAX_WAIT  (MAX_WAIT),
    .MAX_RETRY (MAX_RETRY)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .alloc    (accept_s),
    .alloc_id (cmd_page_id),
    .rsp_vld  (response[RSP_VLD]),
    .rsp_id   (response[RSP_ID_LSB +: PAGE_ID_W]),
    .free_any (free_any_s),
    .due_any  (due_any_s),
    .due_id   (due_id_s),
    .hit      (hit_s),
    .abandon  (abandon_s),
    .any_busy (any_busy_s)
  );

  // A due retry owns the request slot, so intake stalls that cycle
  assign open_s    = (state_r == ST_IDLE) || (state_r == ST_COLLECT);
  assign cmd_ready = !reset && open_s && free_any_s && !due_any_s;
  assign accept_s  = cmd_valid && cmd_ready;

  assign sum_ext_s = {1'b0, sum_r} + {{(SUM_W + 1 - DATA_W){1'b0}}, rsp_val_s};
  assign sum_sat_s = sum_ext_s[SUM_W] ? {SUM_W{1'b1}} : sum_ext_s[SUM_W-1:0];

  // Batch FSM next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        if (accept_s && cmd_last) begin
          state_s = ST_DRAIN;
        end else if (accept_s) begin
          state_s = ST_COLLECT;
        end else begin
          state_s = state_r;
        end
      end
      ST_DRAIN: begin
        if (!any_busy_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, request register, accumulator and batch status
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      request_r   <= '0;
      sum_r       <= '0;
      sum_err_r   <= 1'b0;
      sum_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      sum_valid_r <= (state_s == ST_DONE);
      if (due_any_s) begin
        request_r <= pack_req(due_id_s);
      end else if (accept_s) begin
        request_r <= pack_req(cmd_page_id);
      end else begin
        request_r <= '0;
      end
      if (accept_s && (state_r == ST_IDLE)) begin
        sum_r     <= '0;
        sum_err_r <= 1'b0;
      end else begin
        if (hit_s) begin
          sum_r <= sum_sat_s;
        end
        if (abandon_s) begin
          sum_err_r <= 1'b1;
        end
      end
    end
  end

  assign request   = request_r;
  assign sum       = sum_r;
  assign sum_err   = sum_err_r;
  assign sum_valid = sum_valid_r;

endmodule

// File: tb/tb_noc_fetch_ctrl.sv
// Directed bench for noc_fetch_ctrl: a default instance plus a SUM_W=16
// instance sharing the same stimulus for the saturation scenario.
module tb_noc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [5:0]  cmd_page_id = 6'd0;
  logic        cmd_last = 1'b0;
  logic [22:0] response = 23'd0;

  logic        cmd_ready;
  logic [6:0]  request;
  logic        sum_valid;
  logic [23:0] sum;
  logic        sum_err;

  logic        cmd_ready16;
  logic [6:0]  request16;
  logic        sum_valid16;
  logic [15:0] sum16;
  logic        sum_err16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  noc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_page_id(cmd_page_id), .cmd_last(cmd_last), .request(request),
    .response(response), .sum_valid(sum_valid), .sum(sum), .sum_err(sum_err)
  );

  noc_fetch_ctrl #(.SUM_W(16)) dut16 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready16),
    .cmd_page_id(cmd_page_id), .cmd_last(cmd_last), .request(request16),
    .response(response), .sum_valid(sum_valid16), .sum(sum16), .sum_err(sum_err16)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_sum(input int limit, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      #1;
      if (sum_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    #1;
    n_vec++; if (request !== 7'h00) begin n_err++; $display("FAIL rst_request: got %h want 00", request); end
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    n_vec++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL rst_sum_valid: got %b want 0", sum_valid); end
    n_vec++; if (sum !== 24'h0) begin n_err++; $display("FAIL rst_sum: got %h want 000000", sum); end
    n_vec++; if (sum_err !== 1'b0) begin n_err++; $display("FAIL rst_sum_err: got %b want 0", sum_err); end
    reset = 1'b0;
    cyc();
    #1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); end
    cyc();
  endtask

  task automatic test_single();
    logic [6:0] exp_req;
    for (int c = 0; c <= 14; c++) begin
      cmd_valid   = (c == 0);
      cmd_page_id = 6'd5;
      cmd_last    = (c == 0);
      response    = (c == 10) ? {16'h0100, 6'd5, 1'b1} : 23'd0;
      #1;
      exp_req = (c == 1) ? 7'h45 : 7'h00;
      n_vec++; if (request !== exp_req) begin n_err++; $display("FAIL single_req c=%0d: got %h want %h", c, request, exp_req); end
      n_vec++; if (sum_valid !== (c == 12)) begin n_err++; $display("FAIL single_sum_valid c=%0d: got %b want %b", c, sum_valid, (c == 12)); end
      if (c == 0) begin
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", cmd_ready); end
      end
      if (c == 5) begin
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL drain_ready: got %b want 0", cmd_ready); end
      end
      if (c == 12) begin
        n_vec++; if (sum !== 24'h000100) begin n_err++; $display("FAIL single_sum: got %h want 000100", sum); end
        n_vec++; if (sum_err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", sum_err); end
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] exp_req;
    bit seen;
    for (int i = 1; i <= 4; i++) begin
      cmd_valid = 1'b1; cmd_page_id = 6'(i); cmd_last = 1'b0;
      #1;
      n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready id=%0d: got %b want 1", i, cmd_ready); end
      if (i > 1) begin
        exp_req = {1'b1, 6'(i - 1)};
        n_vec++; if (request !== exp_req) begin n_err++; $display("FAIL bp_req id=%0d: got %h want %h", i - 1, request, exp_req); end
      end
      cyc();
    end
    cmd_page_id = 6'd5; cmd_last = 1'b1;
    #1;
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", cmd_ready); end
    n_vec++; if (request !== 7'h44) begin n_err++; $display("FAIL bp_req4: got %h want 44", request); end
    cyc();
    #1;
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready2: got %b want 0", cmd_ready); end
    n_vec++; if (request !== 7'h00) begin n_err++; $display("FAIL bp_no_req: got %h want 00", request); end
    cyc();
    response = {16'h0002, 6'd2, 1'b1};
    #1;
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_same_cycle_reuse: got %b want 0", cmd_ready); end
    cyc();
    response = 23'd0;
    #1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL bp_reuse_ready: got %b want 1", cmd_ready); end
    cyc();
    cmd_valid = 1'b0; cmd_last = 1'b0;
    response = {16'h0001, 6'd1, 1'b1};
    #1;
    n_vec++; if (request !== 7'h45) begin n_err++; $display("FAIL bp_req5: got %h want 45", request); end
    cyc();
    response = {16'h0003, 6'd3, 1'b1};
    cyc();
    response = {16'h0004, 6'd4, 1'b1};
    cyc();
    response = {16'h0005, 6'd5, 1'b1};
    cyc();
    response = 23'd0;
    wait_sum(10, seen);
    n_vec++; if (!seen) begin n_err++; $display("FAIL bp_sum_valid: got none want pulse"); end
    n_vec++; if (sum !== 24'h00000F) begin n_err++; $display("FAIL bp_sum: got %h want 00000f", sum); end
    n_vec++; if (sum_err !== 1'b0) begin n_err++; $display("FAIL bp_err: got %b want 0", sum_err); end
    cyc();
  endtask

  task automatic test_out_of_order();
    int pulses;
    logic [23:0] got_sum;
    logic got_err;
    cmd_valid = 1'b1; cmd_page_id = 6'd3; cmd_last = 1'b0;
    #1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ooo_ready: got %b want 1", cmd_ready); end
    cyc();
    cmd_page_id = 6'd4;
    #1;
    n_vec++; if (sum !== 24'h0) begin n_err++; $display("FAIL ooo_sum_clear: got %h want 000000", sum); end
    cyc();
    cmd_page_id = 6'd6; cmd_last = 1'b1;
    cyc();
    cmd_valid = 1'b0; cmd_last = 1'b0;
    #1;
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL ooo_drain_ready: got %b want 0", cmd_ready); end
    cyc();
    response = {16'h0077, 6'd9, 1'b1};
    cyc();
    response = {16'h0030, 6'd6, 1'b1};
    cyc();
    response = {16'h0010, 6'd3, 1'b1};
    cyc();
    response = {16'h0020, 6'd4, 1'b1};
    cyc();
    response = 23'd0;
    pulses = 0; got_sum = 24'h0; got_err = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (sum_valid === 1'b1) begin
        pulses++; got_sum = sum; got_err = sum_err;
      end
      cyc();
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL ooo_pulses: got %0d want 1", pulses); end
    n_vec++; if (got_sum !== 24'h000060) begin n_err++; $display("FAIL ooo_sum: got %h want 000060", got_sum); end
    n_vec++; if (got_err !== 1'b0) begin n_err++; $display("FAIL ooo_err: got %b want 0", got_err); end
  endtask

  task automatic test_timeout();
    logic [6:0] exp_req;
    for (int c = 0; c <= 134; c++) begin
      cmd_valid   = (c == 0) || (c == 40);
      cmd_page_id = (c == 40) ? 6'd8 : 6'd7;
      cmd_last    = (c == 40);
      response    = (c == 45) ? {16'h0000, 6'd8, 1'b1} : 23'd0;
      #1;
      if (c == 1 || c == 33 || c == 65 || c == 97) exp_req = 7'h47;
      else if (c == 41) exp_req = 7'h48;
      else exp_req = 7'h00;
      n_vec++; if (request !== exp_req) begin n_err++; $display("FAIL to_req c=%0d: got %h want %h", c, request, exp_req); end
      n_vec++; if (sum_valid !== (c == 130)) begin n_err++; $display("FAIL to_sum_valid c=%0d: got %b want %b", c, sum_valid, (c == 130)); end
      if (c == 31) begin
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL to_ready_pre: got %b want 1", cmd_ready); end
      end
      if (c == 32) begin
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL to_ready_retry: got %b want 0", cmd_ready); end
      end
      if (c == 130) begin
        n_vec++; if (sum_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", sum_err); end
        n_vec++; if (sum !== 24'h0) begin n_err++; $display("FAIL to_sum: got %h want 000000", sum); end
      end
      cyc();
    end
  endtask

  task automatic test_sat_collision();
    logic [6:0] exp_req;
    for (int c = 0; c <= 38; c++) begin
      cmd_valid   = (c < 2);
      cmd_page_id = (c == 0) ? 6'd10 : 6'd11;
      cmd_last    = (c == 1);
      if (c == 3) response = {16'hFFFF, 6'd10, 1'b1};
      else if (c == 33) response = {16'h0002, 6'd11, 1'b1};
      else response = 23'd0;
      #1;
      if (c == 1) exp_req = 7'h4A;
      else if (c == 2) exp_req = 7'h4B;
      else exp_req = 7'h00;
      n_vec++; if (request !== exp_req) begin n_err++; $display("FAIL col_req c=%0d: got %h want %h", c, request, exp_req); end
      n_vec++; if (request16 !== exp_req) begin n_err++; $display("FAIL col_req16 c=%0d: got %h want %h", c, request16, exp_req); end
      n_vec++; if (sum_valid !== (c == 35)) begin n_err++; $display("FAIL col_sum_valid c=%0d: got %b want %b", c, sum_valid, (c == 35)); end
      if (c == 0) begin
        n_vec++; if (cmd_ready16 !== 1'b1) begin n_err++; $display("FAIL col_ready16: got %b want 1", cmd_ready16); end
      end
      if (c == 35) begin
        n_vec++; if (sum !== 24'h010001) begin n_err++; $display("FAIL col_sum24: got %h want 010001", sum); end
        n_vec++; if (sum16 !== 16'hFFFF) begin n_err++; $display("FAIL sat_sum16: got %h want ffff", sum16); end
        n_vec++; if (sum_valid16 !== 1'b1) begin n_err++; $display("FAIL sat_valid16: got %b want 1", sum_valid16); end
        n_vec++; if (sum_err !== 1'b0 || sum_err16 !== 1'b0) begin n_err++; $display("FAIL col_err: got %b/%b want 0/0", sum_err, sum_err16); end
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid_batch();
    cmd_valid = 1'b1; cmd_page_id = 6'd20; cmd_last = 1'b0;
    cyc();
    cmd_page_id = 6'd21;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", cmd_ready); end
    cyc();
    #1;
    n_vec++; if (request !== 7'h00) begin n_err++; $display("FAIL mid_rst_req: got %h want 00", request); end
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready2: got %b want 0", cmd_ready); end
    cyc();
    reset = 1'b0;
    for (int c = 5; c <= 60; c++) begin
      if (c == 6) response = {16'h0011, 6'd20, 1'b1};
      else if (c == 7) response = {16'h0011, 6'd21, 1'b1};
      else response = 23'd0;
      #1;
      n_vec++; if (request !== 7'h00) begin n_err++; $display("FAIL mid_req c=%0d: got %h want 00", c, request); end
      n_vec++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL mid_sum_valid c=%0d: got %b want 0", c, sum_valid); end
      cyc();
    end
    #1;
    n_vec++; if (sum !== 24'h0) begin n_err++; $display("FAIL mid_sum: got %h want 000000", sum); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_after: got %b want 1", cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_out_of_order();
    test_timeout();
    test_sat_collision();
    test_reset_mid_batch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noc_fetch_ctrl.md
Name: noc_fetch_ctrl

Overview:
- Per-engine fetch controller on the page-rank NoC, one instance per engine port.
- Upstream of the NoC: takes a stream of neighbour page ids from a rank engine and drives that port's 7-bit request input.
- Downstream of the NoC: consumes that port's response output and matches out-of-order replies against a scoreboard of outstanding fetches.
- Retries fetches that time out, accumulates the returned values into a saturating sum, and reports one result per batch.

Parameters:
- DATA_W, 16, width of the reply value field in a response.
- SUM_W, 24, accumulator width; must be >= DATA_W.
- MAX_OUT, 4, scoreboard entries, which is the maximum number of outstanding fetches (2..8).
- MAX_WAIT, 31, cycles to wait for a response before a retry.
- MAX_RETRY, 3, re-issues allowed per entry before that entry is abandoned.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- cmd_valid  in  1  a neighbour page id is offered.
- cmd_ready  out  1  the block accepts the offered id this cycle.
- cmd_page_id  in  6  page id to fetch.
- cmd_last  in  1  the offered id is the last of its batch.
- request  out  7  to the NoC: [6]=valid, [5:0]=page id; valid is a one-cycle pulse per request.
- response  in  DATA_W+7  from the NoC: [DATA_W+6:7]=value, [6:1]=page id, [0]=valid.
- sum_valid  out  1  one-cycle pulse: batch complete.
- sum  out  SUM_W  batch sum; held until the first cmd of the next batch is accepted.
- sum_err  out  1  at least one entry of the batch was abandoned; qualified by sum_valid.

Behaviour:
Reset values: request=0, cmd_ready=0, sum_valid=0, sum=0, sum_err=0, all entries free, state IDLE.

Scoreboard entry fields: busy, page_id[5:0], wait_cnt, retry_cnt.

States:
- IDLE, COLLECT: cmd_ready=1 iff a free entry exists and no retry is due this cycle.
  - Accept occurs when cmd_valid && cmd_ready.
  - An accept allocates the lowest free entry: wait_cnt=0, retry_cnt=0.
  - An accept issues request={1,id} on the next cycle (latency 1).
  - IDLE->COLLECT on the first accept. That accept also clears sum and sum_err.
  - An accept with cmd_last moves to DRAIN, from either IDLE or COLLECT.
- DRAIN: cmd_ready=0. Moves to DONE when no entry is busy.
- DONE: sum_valid=1 for exactly one cycle, then IDLE.

Timing and issue rules:
- Each busy entry increments wait_cnt every cycle.
- When wait_cnt==MAX_WAIT:
  - if retry_cnt<MAX_RETRY, the entry is due for a retry;
  - otherwise the entry is freed and sum_err is set.
- At most one request is issued per cycle.
- A due retry has priority over a new cmd: lowest-index due entry first, and cmd_ready=0 that cycle.
- The retried entry gets wait_cnt=0 and retry_cnt+1. A due entry not serviced holds wait_cnt at MAX_WAIT.
- Result: first retry is 32 cycles after the original request (MAX_WAIT=31).

Response handling:
- response[0]=1 matches the lowest-index busy entry with an equal page_id.
- On a match: the entry is freed and the value is added to sum on the next cycle.
- Addition is unsigned and saturates at 2^SUM_W-1.
- An unmatched response (stray, late duplicate after a retry, post-reset) is ignored.
- Duplicate ids within a batch are legal; each response frees one entry.

Boundary cases:
- A response and a timeout on the same entry in the same cycle: the response wins, with no retry and no error.
- An entry freed by a response is not reusable by an accept in the same cycle. cmd_ready is computed from registered busy bits.
- Scoreboard full: cmd_ready=0, and cmd_valid/cmd_page_id must be held by the source.
- Reset mid-batch: everything is dropped, no sum_valid is produced, and later responses are stray.
- A response arriving in DONE or IDLE matches nothing and is ignored.

Decomposition:
- Shared package noc_pkg holds:
  - request field positions: REQ_VLD=6, REQ_ID_MSB=5;
  - response field positions: RSP_VLD=0, RSP_ID_LSB=1, RSP_VAL_LSB=7;
  - PAGE_ID_W=6;
  - the fetch FSM state enum.
- Sub-module fetch_scoreboard contains:
  - the entry array;
  - free and retry-due priority encoders;
  - id match logic and timers.
- The FSM, request register and accumulator stay in the top level.

Test Plan:
- Single fetch: accept id 5 with cmd_last at cycle 0 -> request=7'h45 at cycle 1 only. Then response {16'h0100,6'd5,1'b1} at cycle 10 -> sum_valid one cycle, sum=24'h000100, sum_err=0.
- Backpressure: offer ids 1..5 back-to-back -> four requests in consecutive cycles, cmd_ready=0 for the fifth. Respond id 2 -> fifth id accepted no earlier than 1 cycle after the response.
- Out-of-order: ids 3,4,6 with values 0x10/0x20/0x30 returned in order 6,3,4, plus a stray response id 9 -> sum=0x60, stray ignored, exactly one sum_valid.
- Timeout: id 7 never answered -> request=7'h47 re-issued at +32, +64 and +96 cycles; entry abandoned 32 cycles after the last retry -> sum_valid with sum_err=1 and sum=0.
- Saturation and collision: SUM_W=16, values 0xFFFF and 0x0002 -> sum=0xFFFF. A response landing on a retry-due cycle -> no retry is issued.
- Reset mid-batch: reset with 2 entries busy -> request=0 and cmd_ready=0 during reset. The following responses are ignored, and no sum_valid occurs.
